// File: rtl/multi_door_controller.sv
// multi_door_controller: N independent garage-door channels, each with a Moore FSM, travel timer and direction memory.
// Optional safety reversal on obstruction while closing is enabled by defining DOOR_OBSTRUCT_REVERSE_EN.
module multi_door_controller #(
    parameter int N_DOORS    = 2,
    parameter int MAX_TRAVEL = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_DOORS-1:0] activate,
    input  logic [N_DOORS-1:0] up_max,
    input  logic [N_DOORS-1:0] dn_max,
    input  logic [N_DOORS-1:0] obstruct,
    input  logic [N_DOORS-1:0] fault_clr,
    output logic [N_DOORS-1:0] up_motor,
    output logic [N_DOORS-1:0] dn_motor,
    output logic [N_DOORS-1:0] fault
);
    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DN, STOPPED, FAULT} state_t;
    localparam int TW = $clog2(MAX_TRAVEL + 1);
    localparam logic [TW-1:0] T_LAST = TW'(MAX_TRAVEL - 1);
    logic [N_DOORS-1:0] obs;
`ifdef DOOR_OBSTRUCT_REVERSE_EN
    assign obs = obstruct;
`else
    logic unused_obstruct;
    assign unused_obstruct = ^obstruct;
    assign obs = '0;
`endif
    genvar d;
    generate
        for (d = 0; d < N_DOORS; d++) begin : g_door
            state_t state, state_nx;
            logic [TW-1:0] timer;
            logic last_dir;
            logic moving, entering;
            always_comb begin
                state_nx = state;
                if (up_max[d] && dn_max[d]) state_nx = FAULT;
                else case (state)
                    IDLE:    if (activate[d]) state_nx = (up_max[d] && !dn_max[d]) ? MOVE_DN : MOVE_UP;
                    MOVE_UP: state_nx = up_max[d] ? IDLE : timer == T_LAST ? FAULT : activate[d] ? STOPPED : MOVE_UP;
                    MOVE_DN: state_nx = dn_max[d] ? IDLE : timer == T_LAST ? FAULT : activate[d] ? STOPPED : obs[d] ? MOVE_UP : MOVE_DN;
                    STOPPED: if (activate[d]) state_nx = last_dir ? MOVE_DN : MOVE_UP;
                    FAULT:   if (fault_clr[d]) state_nx = IDLE;
                    default: state_nx = IDLE;
                endcase
            end
            assign moving   = state == MOVE_UP || state == MOVE_DN;
            // any change into a motion state, including a reversal, restarts the travel count
            assign entering = state_nx != state && (state_nx == MOVE_UP || state_nx == MOVE_DN);
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state    <= IDLE;
                    timer    <= '0;
                    last_dir <= 1'b0;
                end else begin
                    state    <= state_nx;
                    timer    <= entering ? '0 : moving ? timer + 1'b1 : timer;
                    last_dir <= state_nx == MOVE_UP ? 1'b1 : state_nx == MOVE_DN ? 1'b0 : last_dir;
                end
            end
            assign up_motor[d] = state == MOVE_UP;
            assign dn_motor[d] = state == MOVE_DN;
            assign fault[d]    = state == FAULT;
        end
    endgenerate
endmodule

// File: doc/multi_door_controller.md
MULTI_DOOR_CONTROLLER -- requirements
Module: multi_door_controller

Interface
REQ-001 The block SHALL have parameter N_DOORS, default 2, number of independent door channels (1..8).
REQ-002 The block SHALL have parameter MAX_TRAVEL, default 1000, maximum motor-on cycles per travel before fault (2..65535).
REQ-003 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port activate  input  N_DOORS  per-door request pulse or level, sampled each cycle.
REQ-006 The block SHALL have port up_max  input  N_DOORS  per-door fully-open limit sensor.
REQ-007 The block SHALL have port dn_max  input  N_DOORS  per-door fully-closed limit sensor.
REQ-008 The block SHALL have port obstruct  input  N_DOORS  per-door obstruction sensor.
REQ-009 The block SHALL have port fault_clr  input  N_DOORS  per-door fault acknowledge.
REQ-010 The block SHALL have port up_motor  output  N_DOORS  per-door open-motor drive.
REQ-011 The block SHALL have port dn_motor  output  N_DOORS  per-door close-motor drive.
REQ-012 The block SHALL have port fault  output  N_DOORS  per-door fault flag.

Function
REQ-013 Each channel SHALL run an independent FSM (states IDLE, MOVE_UP, MOVE_DN, STOPPED, FAULT), a travel timer sized to hold MAX_TRAVEL, and a last_dir bit (1 = up).
REQ-014 Outputs SHALL be Moore-decoded from the state register: up_motor=1 only in MOVE_UP, dn_motor=1 only in MOVE_DN, fault=1 only in FAULT; up_motor and dn_motor SHALL never both be 1.
REQ-015 In every state, up_max=dn_max=1 (sensor conflict) SHALL force next state FAULT, with highest priority.
REQ-016 IDLE: activate & up_max & !dn_max -> MOVE_DN; activate & !up_max & dn_max -> MOVE_UP; activate with both sensors 0 -> MOVE_UP; otherwise remain IDLE.
REQ-017 MOVE_UP priority after conflict: up_max -> IDLE; timer==MAX_TRAVEL-1 -> FAULT; activate -> STOPPED; else remain.
REQ-018 MOVE_DN priority after conflict: dn_max -> IDLE; timer==MAX_TRAVEL-1 -> FAULT; activate -> STOPPED; obstruct -> per REQ-027/028; else remain.
REQ-019 STOPPED: activate -> MOVE_DN if last_dir=1, MOVE_UP if last_dir=0; else remain; motors off.
REQ-020 FAULT: fault_clr -> IDLE; all other inputs ignored; motors off.
REQ-021 Timer SHALL clear to 0 on every entry to MOVE_UP/MOVE_DN (including reversal), increment by 1 each cycle in those states, and hold otherwise; a full travel therefore drives the motor at most MAX_TRAVEL cycles.
REQ-022 last_dir SHALL update to the direction of each MOVE state entered.
REQ-023 Input-to-output latency SHALL be exactly one clock edge.
REQ-024 Channels SHALL not interact; simultaneous events on different doors SHALL be handled in the same cycle.

Reset
REQ-025 Asserting reset SHALL immediately, without a clock edge, force every channel to IDLE, timer=0, last_dir=0, and all outputs to 0, including mid-travel.
REQ-026 After reset deassertion, the first transition SHALL occur on the next rising clock edge.

Configuration
REQ-027 With macro DOOR_OBSTRUCT_REVERSE_EN defined, obstruct=1 in MOVE_DN SHALL transition to MOVE_UP with timer cleared (safety reversal).
REQ-028 Without DOOR_OBSTRUCT_REVERSE_EN, obstruct SHALL be ignored, the port SHALL remain present, and MOVE_DN SHALL behave as if obstruct=0.

Verification (N_DOORS=2, MAX_TRAVEL=8)
REQ-029 Door0 dn_max=1, activate pulse; up_max=1 raised 5 cycles later -> up_motor[0]=1 for 5 cycles then 0, door1 outputs 0 throughout.
REQ-030 Door0 moving up, limits held 0 -> up_motor[0]=1 exactly 8 cycles, then fault[0]=1; fault_clr pulse -> fault[0]=0 next cycle.
REQ-031 Door1 up_max=1, activate -> dn_motor[1]=1; obstruct pulse at cycle 3 -> up_motor[1]=1 next cycle with macro, dn_motor[1] stays 1 without it.
REQ-032 Door0 moving down, activate at cycle 2 -> STOPPED (motors 0); activate again -> up_motor[0]=1.
REQ-033 Both doors moving, reset asserted between edges -> all outputs 0 before the next edge; up_max=dn_max=1 on door1 -> fault[1]=1 next cycle.
